plru_array: RTL and testbench

//  Per-set tree pseudo-LRU replacement state for an N-way set-associative cache.

---
 rtl/plru_array.sv | 111 +++++++++++
 tb/tb_plru_array.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/plru_array.sv
// Per-set tree pseudo-LRU state with invalid-way preference, registered victim
// output, same-set touch bypass and a one-set-per-cycle flush sweep.
module plru_array #(
    parameter  int SETS  = 4,
    parameter  int WAYS  = 4,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             lkp_en_i,
    input  logic [IDX_W-1:0] lkp_idx_i,
    input  logic [WAYS-1:0]  lkp_way_vld_i,
    output logic             victim_vld_o,
    output logic [WAY_W-1:0] victim_way_o,
    input  logic             touch_en_i,
    input  logic [IDX_W-1:0] touch_idx_i,
    input  logic [WAY_W-1:0] touch_way_i,
    input  logic             flush_i,
    output logic             flush_busy_o
);
    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           ptr_q, ptr_d;
    logic [SETS-1:0][WAYS-2:0]  tree_q, tree_d;
    logic                       victim_vld_q;
    logic [WAY_W-1:0]           victim_way_q, victim_way_d;
    logic [WAYS-2:0]            touched, lkp_tree;

    // Walk w's path from the root, making each node point to the other half.
    function automatic logic [WAYS-2:0] tree_touch(input logic [WAYS-2:0] t,
                                                   input logic [WAY_W-1:0] w);
        logic [WAYS-2:0] r;
        int n;
        r = t;
        n = 0;
        for (int l = 0; l < WAY_W; l++) begin
            r[n] = ~w[WAY_W-1-l];
            n    = 2 * n + 1 + (w[WAY_W-1-l] ? 1 : 0);
        end
        return r;
    endfunction

    function automatic logic [WAY_W-1:0] tree_victim(input logic [WAYS-2:0] t);
        logic [WAY_W-1:0] v;
        int n;
        v = '0;
        n = 0;
        for (int l = 0; l < WAY_W; l++) begin
            v[WAY_W-1-l] = t[n];
            n = 2 * n + 1 + (t[n] ? 1 : 0);
        end
        return v;
    endfunction

    assign touched  = tree_touch(tree_q[touch_idx_i], touch_way_i);
    assign lkp_tree = (state_q == IDLE && touch_en_i && lkp_en_i && touch_idx_i == lkp_idx_i)
                      ? touched : tree_q[lkp_idx_i];

    always_comb begin
        victim_way_d = victim_way_q;
        if (lkp_en_i) begin
            victim_way_d = tree_victim(lkp_tree);
            // Scan downwards so the lowest invalid way wins.
            for (int w = WAYS - 1; w >= 0; w--)
                if (!lkp_way_vld_i[w]) victim_way_d = WAY_W'(w);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        tree_d  = tree_q;
        case (state_q)
            IDLE: begin
                if (touch_en_i) tree_d[touch_idx_i] = touched;
                if (flush_i) begin
                    state_d = FLUSH;
                    ptr_d   = '0;
                end
            end
            FLUSH: begin
                tree_d[ptr_q] = '0;
                ptr_d         = ptr_q + 1'b1;
                if (ptr_q == IDX_W'(SETS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            tree_q       <= '0;
            victim_vld_q <= 1'b0;
            victim_way_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            tree_q       <= tree_d;
            victim_vld_q <= lkp_en_i;
            victim_way_q <= victim_way_d;
        end
    end

    assign victim_vld_o = victim_vld_q;
    assign victim_way_o = victim_way_q;
    assign flush_busy_o = (state_q == FLUSH);
endmodule

// File: tb/tb_plru_array.sv
// Directed bench for plru_array with a recency-timestamp reference model
// compared on every cycle plus hand-computed literal expectations.
module tb_plru_array;
    localparam int SETS = 4;
    localparam int WAYS = 4;

    logic       clk = 0, rst_n = 0;
    logic       lkp_en = 0, touch_en = 0, flush = 0;
    logic [1:0] lkp_idx = 0, touch_idx = 0, touch_way = 0;
    logic [3:0] lkp_vld = 4'hF;
    logic       victim_vld, flush_busy;
    logic [1:0] victim_way;

    int total = 0, bad = 0;

    plru_array #(.SETS(SETS), .WAYS(WAYS)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .lkp_en_i(lkp_en), .lkp_idx_i(lkp_idx), .lkp_way_vld_i(lkp_vld),
        .victim_vld_o(victim_vld), .victim_way_o(victim_way),
        .touch_en_i(touch_en), .touch_idx_i(touch_idx), .touch_way_i(touch_way),
        .flush_i(flush), .flush_busy_o(flush_busy)
    );

    always #5 clk = ~clk;

    // Model: each way remembers when it was last touched (0 = never since clear).
    // A node points to the half NOT holding its subtree's most recent touch,
    // or to the lower half when nothing under it was touched.
    int  ts[SETS][WAYS];
    int  now;
    bit  mbusy;
    int  mptr;
    bit  exp_vld;
    int  exp_way;

    function automatic int model_victim(input int s, input bit byp, input int bw, input logic [3:0] vld);
        int t[WAYS];
        int lo, sz, half, mx, mi;
        for (int w = 0; w < WAYS; w++) if (!vld[w]) return w;
        for (int w = 0; w < WAYS; w++) t[w] = ts[s][w];
        if (byp) t[bw] = now;
        lo = 0;
        sz = WAYS;
        while (sz > 1) begin
            half = sz / 2;
            mx = 0; mi = lo;
            for (int w = lo; w < lo + sz; w++) if (t[w] > mx) begin mx = t[w]; mi = w; end
            if (mx != 0 && mi < lo + half) lo = lo + half;
            sz = half;
        end
        return lo;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) ts[s][w] = 0;
            now = 1; mbusy = 0; mptr = 0; exp_vld = 0; exp_way = 0;
        end else begin
            exp_vld = lkp_en;
            if (lkp_en)
                exp_way = model_victim(int'(lkp_idx), !mbusy && touch_en && touch_idx == lkp_idx,
                                       int'(touch_way), lkp_vld);
            if (!mbusy) begin
                if (touch_en) ts[touch_idx][touch_way] = now;
                if (flush) begin mbusy = 1; mptr = 0; end
            end else begin
                for (int w = 0; w < WAYS; w++) ts[mptr][w] = 0;
                mptr++;
                if (mptr == SETS) mbusy = 0;
            end
            now++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (victim_vld !== exp_vld || flush_busy !== mbusy || int'(victim_way) != exp_way) begin
                bad++;
                $display("FAIL model t=%0t got vld=%0b way=%0d busy=%0b want vld=%0b way=%0d busy=%0b",
                         $time, victim_vld, victim_way, flush_busy, exp_vld, exp_way, mbusy);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic lit(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic touch(input int s, input int w);
        touch_en = 1; touch_idx = 2'(s); touch_way = 2'(w);
        step();
        touch_en = 0;
    endtask

    task automatic lookup(input int s, input logic [3:0] vld, input string name, input int want);
        lkp_en = 1; lkp_idx = 2'(s); lkp_vld = vld;
        step();
        lkp_en = 0; lkp_vld = 4'hF;
        lit({name, "_vld"}, int'(victim_vld), 1);
        lit(name, int'(victim_way), want);
    endtask

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        lit("rst_busy", int'(flush_busy), 0);
        lit("rst_vld", int'(victim_vld), 0);
        lit("rst_way", int'(victim_way), 0);

        lookup(0, 4'hF, "reset_set0", 0);
        step();
        lit("vld_drops", int'(victim_vld), 0);
        lit("way_holds", int'(victim_way), 0);

        touch(1, 0); lookup(1, 4'hF, "t0", 2);
        touch(1, 2); lookup(1, 4'hF, "t2", 1);
        touch(1, 1); lookup(1, 4'hF, "t1", 3);
        touch(1, 3); lookup(1, 4'hF, "t3", 0);

        touch(1, 2); touch(1, 1);
        lookup(1, 4'hF, "tree3", 3);
        lookup(1, 4'b1011, "inv_pref", 2);
        lookup(1, 4'b0000, "inv_low", 0);

        touch_en = 1; touch_idx = 2; touch_way = 0;
        lookup(2, 4'hF, "bypass", 2);
        touch_en = 0;
        touch_en = 1; touch_idx = 3; touch_way = 3;
        lookup(2, 4'hF, "no_bypass_other", 2);
        touch_en = 0;

        touch(0, 0);
        flush = 1; step(); flush = 0;
        cnt = 0;
        while (flush_busy && cnt < 20) begin
            cnt++;
            if (cnt == 2) begin
                flush = 1; touch_en = 1; touch_idx = 0; touch_way = 0;
            end else begin
                flush = 0; touch_en = 0;
            end
            step();
        end
        flush = 0; touch_en = 0;
        lit("flush_cycles", cnt, SETS);
        for (int s = 0; s < SETS; s++) lookup(s, 4'hF, "post_flush", 0);

        touch(1, 0); touch(2, 3);
        flush = 1; step(); flush = 0;
        step();
        rst_n = 0; #1;
        lit("midflush_rst_busy", int'(flush_busy), 0);
        step();
        rst_n = 1;
        for (int s = 0; s < SETS; s++) lookup(s, 4'hF, "post_rst", 0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
